m_debounce_multi: RTL and testbench

Parametrised multi-channel switch debouncer with edge detection. Each channel synchronises a raw mechanical switch input and samples it on a shared slow tick. A change is accepted only after the input has differed from the current debounced state for `STABLE_CNT` consecutive ticks. It sits between board push-buttons/DIP switches and counters or FSMs, which consume the level outputs or the one-cycle `rise`/`fall` pulses.

---
 rtl/m_debounce_multi_pkg.sv | 21 ++
 rtl/m_debounce_ch.sv | 82 ++++++++
 rtl/m_debounce_multi.sv | 53 +++++
 tb/tb_m_debounce_multi.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/m_debounce_multi_pkg.sv
// Shared definitions for the multi-channel switch debouncer: default
// parameter values, the per-channel edge classification and a width helper.
package m_debounce_multi_pkg;

  localparam int unsigned DEF_N_CH       = 4;
  localparam int unsigned DEF_TICK_DIV   = 65536;
  localparam int unsigned DEF_STABLE_CNT = 4;

  // Which pulse, if any, a channel issues when it accepts a new level.
  typedef enum logic [1:0] {
    PULSE_NONE = 2'b00,
    PULSE_RISE = 2'b01,
    PULSE_FALL = 2'b10
  } pulse_e;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/m_debounce_ch.sv
// One debouncer channel: 2-FF synchroniser, stable-tick counter, debounced
// level register and registered one-cycle rise/fall pulses. The channel only
// advances its qualification on cycles where the shared tick is high.
module m_debounce_ch
  import m_debounce_multi_pkg::*;
#(
  parameter int unsigned STABLE_CNT = DEF_STABLE_CNT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic sw_raw,
  output logic sw_out,
  output logic rise,
  output logic fall
);

  // Counter holds 0..STABLE_CNT-1; the width leaves room for STABLE_CNT itself.
  localparam int unsigned CW = cnt_w(STABLE_CNT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic [CW-1:0] stable_cnt;
  logic          differs;
  logic          accept;
  pulse_e        pulse_d;

  // Two-stage synchroniser bringing the raw switch into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state always uses non-blocking assignments so every
    // flop samples the pre-edge value of its neighbours.
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= sw_raw;
      sync_q2 <= sync_q1;
    end
  end

  // Decide whether this tick completes qualification and which pulse follows.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    pulse_d = PULSE_NONE;
    differs = (sync_q2 != sw_out);
    accept  = tick && differs && (stable_cnt == CNT_LAST);
    if (accept) begin
      pulse_d = sync_q2 ? PULSE_RISE : PULSE_FALL;
    end
  end

  // Stable counter and debounced level, advanced only on tick cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_cnt <= '0;
      sw_out     <= 1'b0;
    end else if (tick) begin
      if (!differs) begin
        stable_cnt <= '0;
      end else if (accept) begin
        stable_cnt <= '0;
        sw_out     <= sync_q2;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end

  // Registered edge pulses; they land in the same cycle as the new level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= (pulse_d == PULSE_RISE);
      fall <= (pulse_d == PULSE_FALL);
    end
  end

endmodule

// File: rtl/m_debounce_multi.sv
// Multi-channel switch debouncer. A single prescaler produces a one-cycle
// sample tick every TICK_DIV clocks; each channel qualifies level changes
// over STABLE_CNT consecutive differing ticks and emits rise/fall pulses.
module m_debounce_multi
  import m_debounce_multi_pkg::*;
#(
  parameter int unsigned N_CH       = DEF_N_CH,
  parameter int unsigned TICK_DIV   = DEF_TICK_DIV,
  parameter int unsigned STABLE_CNT = DEF_STABLE_CNT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] sw_in,
  output logic [N_CH-1:0] sw_out,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic            tick
);

  localparam int unsigned PW = cnt_w(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre_cnt;
  logic          pre_wrap;

  assign pre_wrap = (pre_cnt == PRE_LAST);

  // Prescaler 0..TICK_DIV-1 and its registered, glitch-free tick strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      tick    <= pre_wrap;
      pre_cnt <= pre_wrap ? '0 : pre_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    m_debounce_ch #(
      .STABLE_CNT (STABLE_CNT)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .tick   (tick),
      .sw_raw (sw_in[i]),
      .sw_out (sw_out[i]),
      .rise   (rise[i]),
      .fall   (fall[i])
    );
  end

endmodule

// File: tb/tb_m_debounce_multi.sv
// Self-checking bench for m_debounce_multi (N_CH=2, TICK_DIV=4, STABLE_CNT=3).
// A reference model keeps the last STABLE_CNT tick samples and flips a
// channel when all of them disagree with its current level; every cycle the
// DUT outputs are compared to it, alongside hand-derived table vectors.
module tb_m_debounce_multi;

  localparam int N_CH       = 2;
  localparam int TICK_DIV   = 4;
  localparam int STABLE_CNT = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [N_CH-1:0] sw_in = '0;
  logic [N_CH-1:0] sw_out;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] fall;
  logic            tick;

  m_debounce_multi #(
    .N_CH       (N_CH),
    .TICK_DIV   (TICK_DIV),
    .STABLE_CNT (STABLE_CNT)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sw_in  (sw_in),
    .sw_out (sw_out),
    .rise   (rise),
    .fall   (fall),
    .tick   (tick)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  int              cyc;
  logic            m_tick;
  logic [N_CH-1:0] m_s1, m_s2, m_lvl, m_rise, m_fall;
  logic [N_CH-1:0] hist[$];

  // Pulse tallies observed on the DUT, used by the table and hand sequences.
  int cnt_rise[N_CH];
  int cnt_fall[N_CH];
  int cnt_tick;
  int cnt_both;

  typedef struct {
    logic [N_CH-1:0] sw;
    int              hold;
    logic [N_CH-1:0] exp_out;
    int              r0, r1, f0, f1;
    int              ticks;
    int              both;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_clear();
    cyc    = 0;
    m_tick = 1'b0;
    m_s1   = '0;
    m_s2   = '0;
    m_lvl  = '0;
    m_rise = '0;
    m_fall = '0;
    hist.delete();
  endtask

  task automatic clear_counts();
    for (int c = 0; c < N_CH; c++) begin
      cnt_rise[c] = 0;
      cnt_fall[c] = 0;
    end
    cnt_tick = 0;
    cnt_both = 0;
  endtask

  // Trailing tick samples on channel ch that disagree with the model level.
  function automatic int tail_diff(input int ch);
    int n;
    n = 0;
    for (int k = hist.size() - 1; k >= 0; k--) begin
      if (hist[k][ch] == m_lvl[ch]) break;
      n++;
    end
    return n;
  endfunction

  // One clock: advance the model on the rising edge, compare on the falling.
  task automatic clk_step();
    logic [N_CH-1:0] r, f;
    bit              all_diff;
    @(posedge clk);
    cyc++;
    r = '0;
    f = '0;
    if (m_tick) begin
      hist.push_back(m_s2);
      if (hist.size() > STABLE_CNT) void'(hist.pop_front());
      if (hist.size() == STABLE_CNT) begin
        for (int ch = 0; ch < N_CH; ch++) begin
          all_diff = 1'b1;
          for (int k = 0; k < STABLE_CNT; k++)
            if (hist[k][ch] == m_lvl[ch]) all_diff = 1'b0;
          if (all_diff) begin
            m_lvl[ch] = ~m_lvl[ch];
            if (m_lvl[ch]) r[ch] = 1'b1;
            else           f[ch] = 1'b1;
          end
        end
      end
    end
    m_s2   = m_s1;
    m_s1   = sw_in;
    m_tick = (cyc % TICK_DIV == 0);
    m_rise = r;
    m_fall = f;
    @(negedge clk);
    check("sw_out", 32'(sw_out), 32'(m_lvl));
    check("rise",   32'(rise),   32'(m_rise));
    check("fall",   32'(fall),   32'(m_fall));
    check("tick",   32'(tick),   32'(m_tick));
    for (int c = 0; c < N_CH; c++) begin
      cnt_rise[c] += int'(rise[c]);
      cnt_fall[c] += int'(fall[c]);
    end
    cnt_tick += int'(tick);
    if (rise == 2'b11) cnt_both++;
  endtask

  // Assert reset, confirm the asynchronous clear, then release on a falling edge.
  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check("rst_sw_out", 32'(sw_out), 32'd0);
    check("rst_rise",   32'(rise),   32'd0);
    check("rst_fall",   32'(fall),   32'd0);
    check("rst_tick",   32'(tick),   32'd0);
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    //            sw     hold out    r0 r1 f0 f1 ticks both
    vecs[0] = '{2'b00, 16, 2'b00, 0, 0, 0, 0, 4, 0};
    vecs[1] = '{2'b01, 16, 2'b01, 1, 0, 0, 0, 4, 0};
    vecs[2] = '{2'b01,  8, 2'b01, 0, 0, 0, 0, 2, 0};
    vecs[3] = '{2'b00, 16, 2'b00, 0, 0, 1, 0, 4, 0};
    vecs[4] = '{2'b11, 16, 2'b11, 1, 1, 0, 0, 4, 1};
    vecs[5] = '{2'b10, 16, 2'b10, 0, 0, 1, 0, 4, 0};
    vecs[6] = '{2'b00, 16, 2'b00, 0, 0, 0, 1, 4, 0};

    #2;
    apply_reset();

    // Table-driven directed vectors.
    for (int v = 0; v < 7; v++) begin
      clear_counts();
      sw_in = vecs[v].sw;
      repeat (vecs[v].hold) clk_step();
      check($sformatf("vec%0d_sw_out", v), 32'(sw_out),    32'(vecs[v].exp_out));
      check($sformatf("vec%0d_rise0", v),  32'(cnt_rise[0]), 32'(vecs[v].r0));
      check($sformatf("vec%0d_rise1", v),  32'(cnt_rise[1]), 32'(vecs[v].r1));
      check($sformatf("vec%0d_fall0", v),  32'(cnt_fall[0]), 32'(vecs[v].f0));
      check($sformatf("vec%0d_fall1", v),  32'(cnt_fall[1]), 32'(vecs[v].f1));
      check($sformatf("vec%0d_ticks", v),  32'(cnt_tick),    32'(vecs[v].ticks));
      check($sformatf("vec%0d_both", v),   32'(cnt_both),    32'(vecs[v].both));
    end

    // Bounce on channel 0: toggle every 3 cycles for 30 cycles, then hold high.
    clear_counts();
    for (int seg = 0; seg < 10; seg++) begin
      sw_in = {1'b0, (seg % 2 == 0)};
      repeat (3) clk_step();
    end
    check("bounce_sw_out", 32'(sw_out),      32'd0);
    check("bounce_rise0",  32'(cnt_rise[0]), 32'd0);
    check("bounce_fall0",  32'(cnt_fall[0]), 32'd0);
    clear_counts();
    sw_in = 2'b01;
    repeat (16) clk_step();
    check("settle_sw_out", 32'(sw_out),      32'd1);
    check("settle_rise0",  32'(cnt_rise[0]), 32'd1);
    check("settle_fall0",  32'(cnt_fall[0]), 32'd0);
    check("settle_rise1",  32'(cnt_rise[1]), 32'd0);

    // Channel 1 qualifies for two ticks, then reset lands mid-qualification.
    sw_in = 2'b11;
    for (int i = 0; i < 24; i++) begin
      clk_step();
      if (tail_diff(1) == 2) break;
    end
    check("midq_pre_sw_out", 32'(sw_out), 32'd1);
    apply_reset();
    repeat (12) clk_step();
    check("post_rst_wait_sw_out", 32'(sw_out), 32'd0);
    clear_counts();
    clk_step();
    check("post_rst_accept_sw_out", 32'(sw_out),   32'd3);
    check("post_rst_accept_both",   32'(cnt_both), 32'd1);

    // Randomised levels and hold times against the reference model.
    for (int i = 0; i < 300; i++) begin
      sw_in = 2'($urandom_range(0, 3));
      repeat ($urandom_range(1, 18)) clk_step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
